// File: rtl/conv_window_ctrl_if.sv
// Pixel-stream and window-tap bundle between the frame source,
// conv_window_ctrl and the 3x3 conv pipeline.
interface conv_window_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] pix_in;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [DATA_WIDTH-1:0] win0;
    logic [DATA_WIDTH-1:0] win1;
    logic [DATA_WIDTH-1:0] win2;
    logic [DATA_WIDTH-1:0] win3;
    logic [DATA_WIDTH-1:0] win4;
    logic [DATA_WIDTH-1:0] win5;
    logic [DATA_WIDTH-1:0] win6;
    logic [DATA_WIDTH-1:0] win7;
    logic [DATA_WIDTH-1:0] win8;
    logic                  win_valid;
    logic                  conv_valid;

    modport master (
        output pix_in, pix_valid, conv_valid,
        input  pix_ready, win_valid,
        input  win0, win1, win2, win3, win4,
        input  win5, win6, win7, win8
    );

    modport slave (
        input  pix_in, pix_valid, conv_valid,
        output pix_ready, win_valid,
        output win0, win1, win2, win3, win4,
        output win5, win6, win7, win8
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// Raster-stream 3x3 window sequencer for the conv pipeline.
// Define CONV_STRIDE2_EN for stride-2 window emission.
module conv_window_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    conv_window_ctrl_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  out_count
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
`ifdef CONV_STRIDE2_EN
    localparam int EXP_I = ((IMG_W - 1) / 2) * ((IMG_H - 1) / 2);
`else
    localparam int EXP_I = (IMG_W - 2) * (IMG_H - 2);
`endif
    localparam logic [CNT_W-1:0] EXP     = CNT_W'(EXP_I);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wv_q, wv_d;
    logic [DATA_WIDTH-1:0] win_q [9];
    logic [DATA_WIDTH-1:0] win_d [9];
    logic [DATA_WIDTH-1:0] lb0_q [IMG_W];
    logic [DATA_WIDTH-1:0] lb0_d [IMG_W];
    logic [DATA_WIDTH-1:0] lb1_q [IMG_W];
    logic [DATA_WIDTH-1:0] lb1_d [IMG_W];
    logic                  accept;
    logic                  stride_ok;

    assign accept = bus.pix_valid && (state_q == STREAM);

`ifdef CONV_STRIDE2_EN
    // (row-2) and (col-2) even is the same as row and col even
    assign stride_ok = ~row_q[0] & ~col_q[0];
`else
    assign stride_ok = 1'b1;
`endif

    // Next-state, counters, window shift and line-buffer update
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        wv_d    = 1'b0;
        win_d   = win_q;
        lb0_d   = lb0_q;
        lb1_d   = lb1_q;

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]   = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
            end
            win_d[2]     = lb0_q[col_q];
            win_d[5]     = lb1_q[col_q];
            win_d[8]     = bus.pix_in;
            lb0_d[col_q] = lb1_q[col_q];
            lb1_d[col_q] = bus.pix_in;
            wv_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO) && stride_ok;
        end

        if (bus.conv_valid && (state_q == STREAM || state_q == DRAIN)
            && cnt_q != EXP) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    col_d   = '0;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (col_q == COL_MAX) begin
                        col_d = '0;
                        if (row_q == ROW_MAX) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == EXP) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and window registers, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            wv_q    <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            wv_q    <= wv_d;
            win_q   <= win_d;
        end
    end

    // Line buffers hold pixel data only, so they carry no reset
    always_ff @(posedge clk) begin
        lb0_q <= lb0_d;
        lb1_q <= lb1_d;
    end

    assign bus.pix_ready = (state_q == STREAM);
    assign bus.win_valid = wv_q;
    assign bus.win0      = win_q[0];
    assign bus.win1      = win_q[1];
    assign bus.win2      = win_q[2];
    assign bus.win3      = win_q[3];
    assign bus.win4      = win_q[4];
    assign bus.win5      = win_q[5];
    assign bus.win6      = win_q[6];
    assign bus.win7      = win_q[7];
    assign bus.win8      = win_q[8];
    assign busy          = (state_q == STREAM) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign out_count     = cnt_q;
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: 8x8 frames with a
// 5-cycle conv model; follows CONV_STRIDE2_EN if defined.
module tb_conv_window_ctrl;
    localparam int DW = 32;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = 16;
`ifdef CONV_STRIDE2_EN
    localparam int ST = 2;
`else
    localparam int ST = 1;
`endif
    localparam int NW  = (W - 2 + ST - 1) / ST;
    localparam int NH  = (H - 2 + ST - 1) / ST;
    localparam int EXP = NW * NH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] out_count;
    logic [4:0]    pipe;
    logic          spur = 1'b0;
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            max_cnt = 0;
    logic [9*DW-1:0] wins [$];

    conv_window_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    conv_window_ctrl #(
        .DATA_WIDTH(DW),
        .IMG_W(W),
        .IMG_H(H),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    // conv pipeline model: fixed 5-cycle latency
    always @(posedge clk or posedge rst) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[3:0], bus.win_valid};
    end
    assign bus.conv_valid = pipe[4] | spur;

    function automatic logic [9*DW-1:0] taps();
        return {bus.win0, bus.win1, bus.win2, bus.win3, bus.win4,
                bus.win5, bus.win6, bus.win7, bus.win8};
    endfunction

    // window whose newest pixel is (r,c), pixel value = r*W+c
    function automatic logic [9*DW-1:0] exp_win(int r, int c);
        logic [9*DW-1:0] res;
        res = '0;
        for (int k = 0; k < 9; k++) begin
            res = (res << DW) | (9*DW)'((r - 2 + k / 3) * W + (c - 2 + k % 3));
        end
        return res;
    endfunction

    always @(negedge clk) begin
        if (bus.win_valid) wins.push_back(taps());
        if (done) done_cnt++;
        if (int'(out_count) > max_cnt) max_cnt = int'(out_count);
    end

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_pixels(input int start_at, input int n_pix);
        int p = 0;
        int cyc = 0;
        while (p < n_pix && cyc < 1000) begin
            bus.pix_valid = 1'b1;
            bus.pix_in    = DW'(p);
            start         = (p == start_at);
            if (bus.pix_valid && bus.pix_ready) p++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        bus.pix_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int base = done_cnt;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > base) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        ok = (done_cnt > base);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.pix_ready, bus.win_valid, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000",
                     {bus.pix_ready, bus.win_valid, busy, done});
        end
        checks++;
        if (out_count !== '0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", out_count);
        end
        checks++;
        if (taps() !== '0) begin
            errors++;
            $display("FAIL reset_taps got %h want 0", taps());
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stream(input int start_at, input string nm);
        int bw = wins.size();
        int bd = done_cnt;
        bit ok;
        start_frame();
        drive_pixels(start_at, W * H);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done_timeout got none want pulse", nm);
        end
        checks++;
        if (wins.size() - bw != EXP) begin
            errors++;
            $display("FAIL %s_nwin got %0d want %0d", nm, wins.size() - bw, EXP);
        end
        for (int i = 0; i < EXP && bw + i < wins.size(); i++) begin
            checks++;
            if (wins[bw+i] !== exp_win(2 + ST * (i / NW), 2 + ST * (i % NW))) begin
                errors++;
                $display("FAIL %s_win%0d got %h want %h", nm, i, wins[bw+i],
                         exp_win(2 + ST * (i / NW), 2 + ST * (i % NW)));
            end
        end
        checks++;
        if (done_cnt - bd != 1) begin
            errors++;
            $display("FAIL %s_done_cycles got %0d want 1", nm, done_cnt - bd);
        end
        checks++;
        if (out_count !== CW'(EXP) || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_end got cnt=%0d busy=%b want cnt=%0d busy=0",
                     nm, out_count, busy, EXP);
        end
    endtask

    task automatic test_toggle();
        int bw = wins.size();
        int p = 0;
        int cyc = 0;
        bit ok;
        logic [9*DW-1:0] pre;
        start_frame();
        while (p < W * H && cyc < 400) begin
            bus.pix_valid = (cyc % 2 == 0);
            bus.pix_in    = DW'(p);
            if (bus.pix_valid && bus.pix_ready) p++;
            pre = taps();
            @(negedge clk);
            cyc++;
            if (!bus.pix_valid) begin
                checks++;
                if (bus.win_valid !== 1'b0 || taps() !== pre) begin
                    errors++;
                    $display("FAIL gap%0d got wv=%b taps=%h want wv=0 taps=%h",
                             cyc, bus.win_valid, taps(), pre);
                end
            end
        end
        bus.pix_valid = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || wins.size() - bw != EXP) begin
            errors++;
            $display("FAIL toggle_nwin got %0d done=%b want %0d done=1",
                     wins.size() - bw, ok, EXP);
        end
        for (int i = 0; i < EXP && bw + i < wins.size(); i++) begin
            checks++;
            if (wins[bw+i] !== exp_win(2 + ST * (i / NW), 2 + ST * (i % NW))) begin
                errors++;
                $display("FAIL toggle_win%0d got %h want %h", i, wins[bw+i],
                         exp_win(2 + ST * (i / NW), 2 + ST * (i % NW)));
            end
        end
    endtask

    task automatic test_reset_midframe();
        start_frame();
        drive_pixels(-1, 31);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.pix_ready, bus.win_valid, busy, done} !== 4'b0
            || out_count !== '0 || taps() !== '0) begin
            errors++;
            $display("FAIL midrst got ctl=%b cnt=%0d taps=%h want all 0",
                     {bus.pix_ready, bus.win_valid, busy, done}, out_count, taps());
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.pix_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle got rdy=%b busy=%b want 0 0",
                     bus.pix_ready, busy);
        end
        spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        checks++;
        if (out_count !== '0) begin
            errors++;
            $display("FAIL idle_spur got %0d want 0", out_count);
        end
        test_stream(-1, "after_rst");
    endtask

    task automatic test_saturate();
        bit ok;
        start_frame();
        spur = 1'b1;
        drive_pixels(-1, W * H);
        spur = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || out_count !== CW'(EXP)) begin
            errors++;
            $display("FAIL saturate got cnt=%0d done=%b want %0d done=1",
                     out_count, ok, EXP);
        end
        spur = 1'b1;
        repeat (4) @(negedge clk);
        spur = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (out_count !== CW'(EXP) || max_cnt > EXP) begin
            errors++;
            $display("FAIL sat_hold got cnt=%0d max=%0d want %0d", out_count,
                     max_cnt, EXP);
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        test_reset();
        test_stream(-1, "stream");
        test_toggle();
        test_stream(20, "start_ign");
        test_reset_midframe();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end
endmodule
